// File: rtl/reg_file_onehot.sv
// 16 x WIDTH register file driven by one-hot write enables from a 4-to-16 decoder.
// Two async read ports with write-through bypass, hardwired-zero R0, multi-hot write rejection.

module reg_entry #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)  q <= '0;
    else if (wr)   q <= d;
  end
endmodule

module reg_file_onehot #(
  parameter int WIDTH = 16,
  parameter int ERRW  = 8
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [15:0]      WE,
  input  logic [WIDTH-1:0] WD,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic             WriteErr,
  output logic [ERRW-1:0]  ErrCount,
  input  logic             ErrClr
);
  localparam logic [ERRW-1:0] CNT_MAX = '1;

  logic [15:0]            we_rest;
  logic                   multi;
  logic                   onehot;
  logic [15:0][WIDTH-1:0] regs;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign we_rest = WE & (WE - 16'd1);
  assign multi   = |we_rest;
  assign onehot  = (|WE) & ~multi;

  assign regs[0] = '0;

  for (genvar k = 1; k < 16; k++) begin : g_ent
    reg_entry #(.WIDTH(WIDTH)) u_ent (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .wr      (onehot & WE[k]),
      .d       (WD),
      .q       (regs[k])
    );
  end

  // R0 needs no special case in the bypass: regs[0] is zero and RA==0 short-circuits.
  function automatic logic [WIDTH-1:0] rd_sel(input logic [3:0] ra);
    if (ra == 4'd0)            return '0;
    else if (onehot && WE[ra]) return WD;
    else                       return regs[ra];
  endfunction

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (Reset_n) begin
      RD1 = rd_sel(RA1);
      RD2 = rd_sel(RA2);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteErr <= 1'b0;
      ErrCount <= '0;
    end else begin
      WriteErr <= multi;
      if (ErrClr)                            ErrCount <= '0;
      else if (multi && ErrCount != CNT_MAX) ErrCount <= ErrCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_onehot.sv
// Scoreboard bench for reg_file_onehot: stimulus pushes expected outputs from an
// array-based model, a negedge monitor pops and compares.

module tb_reg_file_onehot;
  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [15:0] WE;
  logic [15:0] WD;
  logic [3:0]  RA1, RA2;
  logic [15:0] RD1, RD2;
  logic        WriteErr;
  logic [7:0]  ErrCount;
  logic        ErrClr;

  reg_file_onehot #(.WIDTH(16), .ERRW(8)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .WE(WE), .WD(WD), .RA1(RA1), .RA2(RA2),
    .RD1(RD1), .RD2(RD2), .WriteErr(WriteErr), .ErrCount(ErrCount), .ErrClr(ErrClr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        werr;
    logic [7:0]  ecnt;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // reference model
  int mem[16];
  int m_err;
  int m_cnt;

  function automatic int mrd(input int ra);
    if (!Reset_n) return 0;
    if (ra == 0) return 0;
    if ($countones(WE) == 1 && WE[ra]) return int'(WD);
    return mem[ra];
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 0;
    m_err = 0;
    m_cnt = 0;
  endtask

  // Expectation for the current (pre-edge) cycle, then advance the model across the edge.
  task automatic push_and_update(input string tag);
    exp_t e;
    int pc;
    e.rd1 = 16'(mrd(int'(RA1)));
    e.rd2 = 16'(mrd(int'(RA2)));
    e.werr = m_err[0];
    e.ecnt = 8'(m_cnt);
    e.tag = tag;
    sbq.push_back(e);
    pc = $countones(WE);
    if (pc == 1) begin
      for (int k = 1; k < 16; k++) if (WE[k]) mem[k] = int'(WD);
    end
    m_err = (pc >= 2) ? 1 : 0;
    if (ErrClr) m_cnt = 0;
    else if (pc >= 2 && m_cnt < 255) m_cnt++;
  endtask

  task automatic step(input logic [15:0] we, input logic [15:0] wd,
                      input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic clr, input string tag);
    @(posedge CLK); #1;
    WE = we; WD = wd; RA1 = ra1; RA2 = ra2; ErrClr = clr;
    push_and_update(tag);
  endtask

  task automatic reset_mid(input logic [15:0] we, input logic [15:0] wd,
                           input logic [3:0] ra1, input logic [3:0] ra2);
    exp_t e;
    @(posedge CLK); #1;
    WE = we; WD = wd; RA1 = ra1; RA2 = ra2; ErrClr = 1'b0;
    #1 Reset_n = 1'b0;
    #1;
    chk("async_rst_rd1", int'(RD1), 0);
    chk("async_rst_rd2", int'(RD2), 0);
    model_reset();
    e.rd1 = '0; e.rd2 = '0; e.werr = 1'b0; e.ecnt = '0; e.tag = "in_reset";
    sbq.push_back(e);
    @(posedge CLK); #1;
    WE = '0;
    #2 Reset_n = 1'b1;
    push_and_update("after_release");
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.tag, ".rd1"},  int'(RD1), int'(e.rd1));
      chk({e.tag, ".rd2"},  int'(RD2), int'(e.rd2));
      chk({e.tag, ".werr"}, int'(WriteErr), int'(e.werr));
      chk({e.tag, ".ecnt"}, int'(ErrCount), int'(e.ecnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] we;
    int sel;
    // Reset held with a one-hot write pending: bypass must not leak through.
    Reset_n = 1'b0; WE = 16'h0020; WD = 16'h1234; RA1 = 4'd5; RA2 = 4'd3; ErrClr = 1'b0;
    model_reset();
    #1 push_and_update("reset");
    model_reset();
    #11 Reset_n = 1'b1;

    step(16'h0020, 16'h1234, 5, 3, 0, "wr_r5_bypass");
    step(16'h0000, 16'h0000, 5, 3, 0, "rd_r5");
    step(16'h0080, 16'hBEEF, 7, 7, 0, "bypass_r7");
    step(16'h0000, 16'h0000, 7, 0, 0, "stored_r7");
    step(16'h0001, 16'hFFFF, 0, 0, 0, "r0_write");
    step(16'h0000, 16'h0000, 0, 0, 0, "r0_after");
    step(16'h0008, 16'h1111, 3, 4, 0, "pre_r3");
    step(16'h0018, 16'hAAAA, 3, 4, 0, "multi_hot");
    step(16'h0000, 16'h0000, 3, 4, 0, "multi_err");
    step(16'h0000, 16'h0000, 3, 4, 0, "multi_err_gone");

    for (int i = 0; i < 300; i++) step(16'h0C00 | 16'(1 << (i % 8)), 16'(i), 10, 11, 0, "sat");
    step(16'h0018, 16'h0000, 3, 4, 1, "clr_multi");
    step(16'h0000, 16'h0000, 3, 4, 0, "after_clr");

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 4)       we = '0;
      else if (sel < 12) we = 16'(1 << $urandom_range(0, 15));
      else if (sel < 13) we = 16'h0001;
      else begin
        we = 16'($urandom);
        if ($countones(we) < 2) we = we | 16'h8001;
      end
      step(we, 16'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0), "rand");
    end

    step(16'h0200, 16'h5A5A, 9, 9, 0, "wr_r9");
    step(16'h0018, 16'h0000, 9, 2, 0, "rd_r9");
    reset_mid(16'h0200, 16'h1357, 9, 9);
    step(16'h0000, 16'h0000, 9, 5, 0, "post_reset");

    repeat (3) @(negedge CLK);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_onehot.md
Name: reg_file_onehot

Overview:
- 16-entry x 16-bit register file, directly downstream of the 4-to-16 write-select decoder.
- Write selection arrives as one-hot enables (decoder O0..O15, bundled as WE[15:0]).
- Provides two asynchronous read ports with same-cycle write bypass, hardwired-zero R0, and protection against malformed (multi-hot) write enables with error reporting.

Parameters:
- WIDTH, 16, data width of each register and of WD/RD1/RD2.
- ERRW, 8, width of the saturating error counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- WE  input  16  one-hot write enables; WE[k] selects register k (decoder output Ok).
- WD  input  WIDTH  write data.
- RA1  input  4  read address, port 1.
- RA2  input  4  read address, port 2.
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.
- WriteErr  output  1  registered one-cycle pulse: the previous cycle's WE was multi-hot.
- ErrCount  output  ERRW  saturating count of multi-hot WE cycles.
- ErrClr  input  1  synchronous clear of ErrCount; WriteErr is unaffected.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (Reset_n=0, async):
  - Registers R0..R15 = 0, WriteErr = 0, ErrCount = 0.
  - RD1/RD2 return 0 while reset is asserted, regardless of bypass.
  - A write coincident with the release edge is ignored.
- Write classification, per cycle, on popcount(WE):
  - 0: no write.
  - 1, bit k set: on the rising edge, Rk <= WD, except k=0, where the write is discarded (R0 stays 0).
  - ≥2: no register is written. On the next edge WriteErr <= 1, otherwise WriteErr <= 0. ErrCount increments, saturating at 2^ERRW-1 (holds, no wrap).
- ErrClr=1 at an edge: ErrCount <= 0, taking priority over a simultaneous increment. Same-cycle WriteErr still asserts if WE is multi-hot.
- Read (combinational, zero latency):
  - RDn = R[RAn]; RAn=0 always yields 0.
  - Bypass: if WE is exactly one-hot with bit k, RAn==k and k≠0, then RDn = WD in the same cycle (write-through).
  - Multi-hot WE never bypasses; RDn = stored value.
- Both ports may read the same address simultaneously; each bypasses independently.
- Reset asserted mid-cycle: outputs drop to 0 immediately. The pending write is lost.
- No state machine beyond the register array, WriteErr flop and counter.
- Target size: ~150-250 lines RTL.

Test Plan:
- Reset, then write 0x1234 to R5 (WE=0x0020) at edge 1; read RA1=5 after edge 1 -> RD1=0x1234. RA2=3 -> RD2=0x0000.
- Bypass: RA1=7, WE=0x0080, WD=0xBEEF in the same cycle, before the edge -> RD1=0xBEEF. Change WE to 0 after the edge -> RD1 holds 0xBEEF from storage.
- R0 protection: WE=0x0001, WD=0xFFFF, edge; RA1=0 -> RD1=0x0000, both during that cycle and after it.
- Multi-hot: R3=0x1111 preloaded; WE=0x0018, WD=0xAAAA, edge.
  - R3 and R4 unchanged (RD=0x1111, 0x0000).
  - WriteErr=1 for exactly one cycle; ErrCount=1.
- Saturation/clear:
  - 300 consecutive multi-hot cycles -> ErrCount=255 and holds. WriteErr remains 1 each cycle.
  - ErrClr=1 with multi-hot WE -> ErrCount=0 next cycle.
- Async reset mid-operation: R9=0x5A5A. Assert Reset_n=0 between edges -> RD1 (RA1=9)=0 immediately. Release -> RD1=0x0000; ErrCount=0.
